// File: rtl/hps_pio_pkg.sv
// Shared definitions for the HPS PIO family: register word addresses and
// edge-capture selection codes.
package hps_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // Warm-up counter must hold SYNC_STAGES+1.
  function automatic int warm_width(input int stages);
    return $clog2(stages + 2);
  endfunction

endpackage

// File: rtl/hps_sync_vec.sv
// Multi-flop synchronizer for a vector crossing into the clk domain.
module hps_sync_vec #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [STAGES-1:0][WIDTH-1:0] stage_q;
  logic [STAGES-1:0][WIDTH-1:0] stage_d;

  // Shift chain: stage 0 samples the asynchronous input.
  always_comb begin
    stage_d = {stage_q[STAGES-2:0], din};
  end

  // Chain flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign dout = stage_q[STAGES-1];

endmodule

// File: rtl/hps_input_capture_port.sv
// Avalon-MM input PIO: synchronized fabric vector, sticky edge capture
// with write-1-to-clear, and a maskable level interrupt to the HPS.
module hps_input_capture_port
  import hps_pio_pkg::*;
#(
  parameter int WIDTH       = 10,
  parameter int EDGE_TYPE   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int                WARM_W   = warm_width(SYNC_STAGES);
  localparam logic [WARM_W-1:0] WARM_MAX = WARM_W'(SYNC_STAGES + 1);

  logic [WIDTH-1:0]  sync_q;
  logic [WIDTH-1:0]  prev_q, prev_d;
  logic [WIDTH-1:0]  mask_q, mask_d;
  logic [WIDTH-1:0]  edgecap_q, edgecap_d;
  logic [31:0]       readdata_q, readdata_d;
  logic              irq_q, irq_d;
  logic [WARM_W-1:0] warm_q, warm_d;

  logic              wr_en_s;
  logic [WIDTH-1:0]  edges_s;
  logic [WIDTH-1:0]  clr_s;
  logic [31:0]       rd_word_s;
  logic              unused_wdata_s;

  hps_sync_vec #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (in_port),
    .dout    (sync_q)
  );

  assign wr_en_s        = chipselect & ~write_n;
  assign unused_wdata_s = ^writedata;

  // Edge detection, warm-up gating, capture/clear, mask and read mux.
  always_comb begin
    prev_d = sync_q;

    if (warm_q == WARM_MAX) begin
      warm_d = warm_q;
    end else begin
      warm_d = warm_q + WARM_W'(1);
    end

    case (EDGE_TYPE)
      EDGE_RISE: edges_s = sync_q & ~prev_q;
      EDGE_FALL: edges_s = ~sync_q & prev_q;
      default:   edges_s = sync_q ^ prev_q;
    endcase
    // A level held through reset must not look like an edge while the chain fills.
    if (warm_q != WARM_MAX) begin
      edges_s = '0;
    end else begin
      edges_s = edges_s;
    end

    if (wr_en_s && (address == ADDR_EDGECAP)) begin
      clr_s = writedata[WIDTH-1:0];
    end else begin
      clr_s = '0;
    end
    // Set has priority so a colliding edge is never lost.
    edgecap_d = (edgecap_q & ~clr_s) | edges_s;

    if (wr_en_s && (address == ADDR_IRQMASK)) begin
      mask_d = writedata[WIDTH-1:0];
    end else begin
      mask_d = mask_q;
    end

    irq_d = |(edgecap_d & mask_d);

    rd_word_s = 32'd0;
    case (address)
      ADDR_DATA:    rd_word_s[WIDTH-1:0] = sync_q;
      ADDR_IRQMASK: rd_word_s[WIDTH-1:0] = mask_q;
      ADDR_EDGECAP: rd_word_s[WIDTH-1:0] = edgecap_q;
      default:      rd_word_s = 32'd0;
    endcase

    if (chipselect) begin
      readdata_d = rd_word_s;
    end else begin
      readdata_d = readdata_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q     <= '0;
      mask_q     <= '0;
      edgecap_q  <= '0;
      readdata_q <= 32'd0;
      irq_q      <= 1'b0;
      warm_q     <= '0;
    end else begin
      prev_q     <= prev_d;
      mask_q     <= mask_d;
      edgecap_q  <= edgecap_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
      warm_q     <= warm_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_hps_input_capture_port.sv
// Directed bench: a rising-edge instance and an any-edge instance share
// the address/write bus; each has its own chipselect and input vector.
module tb_hps_input_capture_port;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        cs_r, cs_a;
  logic        write_n;
  logic [31:0] writedata;
  logic [9:0]  in_r, in_a;
  logic [31:0] rd_r, rd_a;
  logic        irq_r, irq_a;
  logic [31:0] rdv;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  hps_input_capture_port #(.WIDTH(10), .EDGE_TYPE(0), .SYNC_STAGES(2)) dut_rise (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_r),
    .write_n(write_n), .writedata(writedata), .in_port(in_r),
    .readdata(rd_r), .irq(irq_r)
  );

  hps_input_capture_port #(.WIDTH(10), .EDGE_TYPE(2), .SYNC_STAGES(2)) dut_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_a),
    .write_n(write_n), .writedata(writedata), .in_port(in_a),
    .readdata(rd_a), .irq(irq_a)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input bit sel, input logic [1:0] a, input logic [31:0] d);
    cs_r = ~sel; cs_a = sel; address = a; write_n = 1'b0; writedata = d;
    tick();
    cs_r = 1'b0; cs_a = 1'b0; write_n = 1'b1; writedata = 32'd0;
  endtask

  task automatic rd(input bit sel, input logic [1:0] a, output logic [31:0] q);
    cs_r = ~sel; cs_a = sel; address = a; write_n = 1'b1;
    tick();
    q = sel ? rd_a : rd_r;
    cs_r = 1'b0; cs_a = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; address = 2'd0; cs_r = 1'b0; cs_a = 1'b0;
    write_n = 1'b1; writedata = 32'd0; in_r = 10'h3FF; in_a = 10'h000;

    // Reset and warm-up with a high level held through reset
    repeat (3) tick();
    check("reset_readdata", rd_r, 32'd0);
    check("reset_irq", {31'd0, irq_r}, 32'd0);
    reset_n = 1'b1;
    repeat (10) tick();
    check("warm_irq", {31'd0, irq_r}, 32'd0);
    rd(1'b0, 2'd3, rdv); check("warm_edgecap", rdv, 32'd0);
    rd(1'b0, 2'd0, rdv); check("data_read", rdv, 32'h3FF);

    // Rising capture on bit0; the preceding fall must be ignored
    wr(1'b0, 2'd2, 32'h1);
    in_r = 10'h3FE;
    repeat (4) tick();
    rd(1'b0, 2'd3, rdv); check("fall_ignored", rdv, 32'd0);
    in_r = 10'h3FF;
    tick(); check("rise_irq_t1", {31'd0, irq_r}, 32'd0);
    tick(); check("rise_irq_t2", {31'd0, irq_r}, 32'd0);
    tick(); check("rise_irq_t3", {31'd0, irq_r}, 32'd1);
    rd(1'b0, 2'd3, rdv); check("rise_edgecap", rdv, 32'h1);
    wr(1'b0, 2'd3, 32'h1); check("w1c_irq", {31'd0, irq_r}, 32'd0);
    rd(1'b0, 2'd3, rdv); check("w1c_edgecap", rdv, 32'd0);

    // Clear/set collision on bit2
    wr(1'b0, 2'd2, 32'h4);
    in_r = 10'h3FB;
    repeat (4) tick();
    in_r = 10'h3FF;
    tick(); tick();
    wr(1'b0, 2'd3, 32'h3FF);
    check("collide_irq", {31'd0, irq_r}, 32'd1);
    rd(1'b0, 2'd3, rdv); check("collide_edgecap", rdv, 32'h4);
    wr(1'b0, 2'd3, 32'h4);

    // Mask latency on bit7
    wr(1'b0, 2'd2, 32'h0);
    in_r = 10'h37F;
    repeat (4) tick();
    in_r = 10'h3FF;
    repeat (5) tick();
    check("masked_irq", {31'd0, irq_r}, 32'd0);
    rd(1'b0, 2'd3, rdv); check("masked_edgecap", rdv, 32'h80);
    wr(1'b0, 2'd2, 32'h80); check("unmask_irq", {31'd0, irq_r}, 32'd1);
    wr(1'b0, 2'd2, 32'h0);  check("remask_irq", {31'd0, irq_r}, 32'd0);
    wr(1'b0, 2'd3, 32'h80);

    // Register map
    wr(1'b0, 2'd2, 32'hFFFF_FFFF);
    rd(1'b0, 2'd2, rdv); check("mask_readback", rdv, 32'h3FF);
    check("mask_all_no_irq", {31'd0, irq_r}, 32'd0);
    wr(1'b0, 2'd1, 32'hFFFF_FFFF);
    rd(1'b0, 2'd1, rdv); check("rsvd_read", rdv, 32'd0);
    wr(1'b0, 2'd0, 32'h0);
    rd(1'b0, 2'd0, rdv); check("data_write_ignored", rdv, 32'h3FF);
    cs_r = 1'b0; address = 2'd1;
    tick(); check("readdata_hold", rd_r, 32'h3FF);

    // Any-edge instance: bit5 pulse high for 4 cycles
    wr(1'b1, 2'd2, 32'h20);
    in_a = 10'h020;
    repeat (3) tick();
    check("any_rise_irq", {31'd0, irq_a}, 32'd1);
    rd(1'b1, 2'd3, rdv); check("any_rise_edgecap", rdv, 32'h20);
    in_a = 10'h000;
    wr(1'b1, 2'd3, 32'h20);
    rd(1'b1, 2'd3, rdv); check("any_cleared", rdv, 32'd0);
    tick();
    rd(1'b1, 2'd3, rdv); check("any_fall_edgecap", rdv, 32'h20);
    check("any_fall_irq", {31'd0, irq_a}, 32'd1);

    // Async reset in the middle of a read burst
    cs_a = 1'b1; address = 2'd3; write_n = 1'b1;
    tick(); check("burst_read", rd_a, 32'h20);
    #2;
    reset_n = 1'b0;
    in_a = 10'h020;
    #1;
    check("async_rd_a", rd_a, 32'd0);
    check("async_irq_a", {31'd0, irq_a}, 32'd0);
    check("async_rd_r", rd_r, 32'd0);
    check("async_irq_r", {31'd0, irq_r}, 32'd0);
    cs_a = 1'b0;
    tick();
    reset_n = 1'b1;
    repeat (10) tick();
    rd(1'b1, 2'd3, rdv); check("rewarm_edgecap", rdv, 32'd0);
    rd(1'b1, 2'd2, rdv); check("rewarm_mask", rdv, 32'd0);
    rd(1'b1, 2'd0, rdv); check("rewarm_data", rdv, 32'h20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
